// File: rtl/controlador_multiciclo.sv
// -----------------------------------------------------------------------------
// controlador_multiciclo
//
// Multicycle sequencer for the processor datapath. Each instruction is stepped
// through BUSCA (fetch), DECODIFICA, EXECUTA, MEMORIA and ESCRITA. The block
// emits one-cycle write enables that gate PC, IR, the register file and the
// data memory. Instruction and data memory share a single port, so this block
// also owns the memory wait counter and the timeout that sends it to ERRO.
//
// Parameters
//   MAX_ESPERA   max consecutive cycles waiting on mem_pronto (1..255)
//   LARG_ESPERA  width of the internal wait counter
//
// Ports
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous active-low reset (0 = reset)
//   Halt, EscReg, Beq, Salto, LerMem, EscMem
//                decoded control signals, driven from IR
//   Zero         ALU zero flag, meaningful in EXECUTA
//   mem_pronto   shared memory port finished its access this cycle
//   LerInstr     instruction read request
//   EscIR        load IR
//   EscPC        PC <= PC + 1
//   EscPCDesvio  PC <= branch/jump target
//   LerMemDados  data read request
//   EscMemDados  data write request
//   EscRegEn     register file write enable
//   estado       current state code
//   parado       halted (sticky until reset)
//   erro         fault (sticky until reset)
//
// Optional feature (compile-time macro CONTADOR_CICLOS_EN)
//   When defined, adds the outputs ciclos[31:0] (cycles spent outside
//   PARADO/ERRO) and instrucoes[31:0] (instructions retired). Both clear on
//   reset and wrap silently. When undefined those ports do not exist.
// -----------------------------------------------------------------------------
module controlador_multiciclo #(
  parameter int unsigned MAX_ESPERA  = 15,
  parameter int unsigned LARG_ESPERA = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Halt,
  input  logic        EscReg,
  input  logic        Beq,
  input  logic        Salto,
  input  logic        LerMem,
  input  logic        EscMem,
  input  logic        Zero,
  input  logic        mem_pronto,
  output logic        LerInstr,
  output logic        EscIR,
  output logic        EscPC,
  output logic        EscPCDesvio,
  output logic        LerMemDados,
  output logic        EscMemDados,
  output logic        EscRegEn,
  output logic [2:0]  estado,
  output logic        parado,
  output logic        erro
`ifdef CONTADOR_CICLOS_EN
  ,
  output logic [31:0] ciclos,
  output logic [31:0] instrucoes
`endif
);

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    PARADO     = 3'd5,
    ERRO       = 3'd6
  } estado_t;

  localparam logic [LARG_ESPERA-1:0] MAX_CNT = LARG_ESPERA'(MAX_ESPERA);

  estado_t                state_q;
  estado_t                state_d;
  logic [LARG_ESPERA-1:0] espera_q;
  logic [LARG_ESPERA-1:0] espera_d;
  logic                   espera_inc;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    espera_inc = 1'b0;
    case (state_q)
      BUSCA: begin
        // A completing access always wins over the timeout.
        if (mem_pronto) begin
          state_d = DECODIFICA;
        end else if (espera_q == MAX_CNT) begin
          state_d = ERRO;
        end else begin
          espera_inc = 1'b1;
        end
      end
      DECODIFICA: begin
        if (Halt) begin
          state_d = PARADO;
        end else if (LerMem && EscMem) begin
          // A simultaneous load and store cannot be sequenced on one port.
          state_d = ERRO;
        end else begin
          state_d = EXECUTA;
        end
      end
      EXECUTA: begin
        if (LerMem || EscMem) begin
          state_d = MEMORIA;
        end else if (Salto || Beq) begin
          // Control transfers never write back, even if EscReg is set.
          state_d = BUSCA;
        end else if (EscReg) begin
          state_d = ESCRITA;
        end else begin
          state_d = BUSCA;
        end
      end
      MEMORIA: begin
        if (mem_pronto) begin
          state_d = LerMem ? ESCRITA : BUSCA;
        end else if (espera_q == MAX_CNT) begin
          state_d = ERRO;
        end else begin
          espera_inc = 1'b1;
        end
      end
      ESCRITA: state_d = BUSCA;
      PARADO:  state_d = PARADO;
      ERRO:    state_d = ERRO;
      default: state_d = ERRO;  // illegal code 7
    endcase
  end

  // The wait counter measures consecutive stalled cycles inside one state, so
  // any state change starts it afresh.
  always_comb begin
    espera_d = espera_q;
    if (state_d != state_q) begin
      espera_d = '0;
    end else if (espera_inc) begin
      espera_d = espera_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= BUSCA;
      espera_q <= '0;
    end else begin
      state_q  <= state_d;
      espera_q <= espera_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Moore on state_q, except the fetch enables (which follow
  // mem_pronto) and the branch enable (which follows Salto/Beq/Zero).
  // Everything except estado is forced low while reset is asserted.
  // ---------------------------------------------------------------------------
  assign estado = state_q;

  always_comb begin
    LerInstr    = 1'b0;
    EscIR       = 1'b0;
    EscPC       = 1'b0;
    EscPCDesvio = 1'b0;
    LerMemDados = 1'b0;
    EscMemDados = 1'b0;
    EscRegEn    = 1'b0;
    parado      = 1'b0;
    erro        = 1'b0;
    if (reset) begin
      case (state_q)
        BUSCA: begin
          LerInstr = 1'b1;
          EscIR    = mem_pronto;
          EscPC    = mem_pronto;
        end
        EXECUTA: begin
          EscPCDesvio = Salto | (Beq & Zero);
        end
        MEMORIA: begin
          LerMemDados = LerMem;
          EscMemDados = EscMem;
        end
        ESCRITA: begin
          EscRegEn = 1'b1;
        end
        PARADO: begin
          parado = 1'b1;
        end
        ERRO: begin
          erro = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CONTADOR_CICLOS_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] ciclos_q;
  logic [31:0] ciclos_d;
  logic [31:0] instrucoes_q;
  logic [31:0] instrucoes_d;
  logic        retira;

  // An instruction retires when the sequencer returns to fetch from any of
  // the states that can end an instruction.
  assign retira = (state_d == BUSCA) &&
                  ((state_q == EXECUTA) || (state_q == MEMORIA) ||
                   (state_q == ESCRITA));

  always_comb begin
    ciclos_d     = ciclos_q;
    instrucoes_d = instrucoes_q;
    if ((state_q != PARADO) && (state_q != ERRO)) begin
      ciclos_d = ciclos_q + 32'd1;
    end
    if (retira) begin
      instrucoes_d = instrucoes_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ciclos_q     <= '0;
      instrucoes_q <= '0;
    end else begin
      ciclos_q     <= ciclos_d;
      instrucoes_q <= instrucoes_d;
    end
  end

  assign ciclos     = reset ? ciclos_q     : 32'd0;
  assign instrucoes = reset ? instrucoes_q : 32'd0;
`endif

endmodule

// File: tb/tb_controlador_multiciclo.sv
// -----------------------------------------------------------------------------
// Testbench for controlador_multiciclo: directed scenarios from the
// instruction-level timing rules plus a randomized instruction stream checked
// cycle by cycle against a trace built from per-instruction phase lists.
// -----------------------------------------------------------------------------
module tb_controlador_multiciclo;

  localparam int MAX_ESPERA = 15;

  // Enable vector layout used by the bench:
  // {LerInstr, EscIR, EscPC, EscPCDesvio, LerMemDados, EscMemDados, EscRegEn}
  localparam logic [6:0] EN_NONE  = 7'b0000000;
  localparam logic [6:0] EN_FETCH = 7'b1000000;
  localparam logic [6:0] EN_IR    = 7'b1110000;
  localparam logic [6:0] EN_DESV  = 7'b0001000;
  localparam logic [6:0] EN_RD    = 7'b0000100;
  localparam logic [6:0] EN_WR    = 7'b0000010;
  localparam logic [6:0] EN_REG   = 7'b0000001;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       Halt = 1'b0, EscReg = 1'b0, Beq = 1'b0, Salto = 1'b0;
  logic       LerMem = 1'b0, EscMem = 1'b0, Zero = 1'b0, mem_pronto = 1'b0;
  logic       LerInstr, EscIR, EscPC, EscPCDesvio;
  logic       LerMemDados, EscMemDados, EscRegEn;
  logic [2:0] estado;
  logic       parado, erro;
  logic [6:0] en;
`ifdef CONTADOR_CICLOS_EN
  logic [31:0] ciclos, instrucoes;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  assign en = {LerInstr, EscIR, EscPC, EscPCDesvio, LerMemDados, EscMemDados, EscRegEn};

  always #5 clock = ~clock;

  controlador_multiciclo #(.MAX_ESPERA(MAX_ESPERA), .LARG_ESPERA(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .Halt       (Halt),
    .EscReg     (EscReg),
    .Beq        (Beq),
    .Salto      (Salto),
    .LerMem     (LerMem),
    .EscMem     (EscMem),
    .Zero       (Zero),
    .mem_pronto (mem_pronto),
    .LerInstr   (LerInstr),
    .EscIR      (EscIR),
    .EscPC      (EscPC),
    .EscPCDesvio(EscPCDesvio),
    .LerMemDados(LerMemDados),
    .EscMemDados(EscMemDados),
    .EscRegEn   (EscRegEn),
    .estado     (estado),
    .parado     (parado),
    .erro       (erro)
`ifdef CONTADOR_CICLOS_EN
    ,
    .ciclos     (ciclos),
    .instrucoes (instrucoes)
`endif
  );

  // Inputs change just after the rising edge; outputs are sampled on the
  // falling edge in between.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_dec(input logic h, input logic r, input logic b,
                         input logic s, input logic lm, input logic em);
    Halt = h; EscReg = r; Beq = b; Salto = s; LerMem = lm; EscMem = em;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
    Zero = 1'b0;
    mem_pronto = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    set_dec(0, 1, 0, 0, 0, 0);
    mem_pronto = 1'b1;
    next_cycle();
    @(negedge clock);
    tests_run++;
    if (estado !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_estado got=%0d exp=0", estado);
    end
    tests_run++;
    if (en !== EN_NONE || parado !== 1'b0 || erro !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs_low en=%b parado=%b erro=%b exp all 0", en, parado, erro);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (en !== EN_IR) begin
      tests_failed++;
      $display("FAIL reset_release_fetch en=%b exp=%b", en, EN_IR);
    end
    next_cycle();
    $display("[TB] test_reset done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_alu();
    logic [2:0] exp_st [4];
    logic [6:0] exp_en [4];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
    exp_en = '{EN_IR, EN_NONE, EN_NONE, EN_REG};
    do_reset();
    set_dec(0, 1, 0, 0, 0, 0);
    mem_pronto = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      tests_run++;
      if (estado !== exp_st[c] || en !== exp_en[c]) begin
        tests_failed++;
        $display("FAIL alu cyc=%0d estado=%0d en=%b exp estado=%0d en=%b",
                 c + 1, estado, en, exp_st[c], exp_en[c]);
      end
      next_cycle();
    end
    @(negedge clock);
    tests_run++;
    if (estado !== 3'd0) begin
      tests_failed++;
      $display("FAIL alu_return estado=%0d exp=0", estado);
    end
    $display("[TB] test_alu done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load();
    logic [2:0] exp_st [8];
    logic [6:0] exp_en [8];
    logic       pr     [8];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    exp_en = '{EN_IR, EN_NONE, EN_NONE, EN_RD, EN_RD, EN_RD, EN_RD, EN_REG};
    pr     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    set_dec(0, 1, 0, 0, 1, 0);
    for (int c = 0; c < 8; c++) begin
      mem_pronto = pr[c];
      @(negedge clock);
      tests_run++;
      if (estado !== exp_st[c] || en !== exp_en[c]) begin
        tests_failed++;
        $display("FAIL load cyc=%0d estado=%0d en=%b exp estado=%0d en=%b",
                 c + 1, estado, en, exp_st[c], exp_en[c]);
      end
      next_cycle();
    end
    @(negedge clock);
    tests_run++;
    if (estado !== 3'd0) begin
      tests_failed++;
      $display("FAIL load_return estado=%0d exp=0", estado);
    end
    $display("[TB] test_load done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      set_dec(0, 0, 1, 0, 0, 0);
      Zero = z[0];
      mem_pronto = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clock);
      tests_run++;
      if (estado !== 3'd2 || EscPCDesvio !== z[0]) begin
        tests_failed++;
        $display("FAIL beq_execute zero=%0d estado=%0d desvio=%b exp estado=2 desvio=%0d",
                 z, estado, EscPCDesvio, z);
      end
      next_cycle();
      @(negedge clock);
      tests_run++;
      if (estado !== 3'd0) begin
        tests_failed++;
        $display("FAIL beq_return zero=%0d estado=%0d exp=0", z, estado);
      end
    end
    $display("[TB] test_branch done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    // Fetch never completes: 16 stalled cycles, ERRO on the 17th edge.
    do_reset();
    mem_pronto = 1'b0;
    for (int c = 0; c <= MAX_ESPERA; c++) begin
      @(negedge clock);
      tests_run++;
      if (estado !== 3'd0 || en !== EN_FETCH) begin
        tests_failed++;
        $display("FAIL timeout_wait cyc=%0d estado=%0d en=%b exp estado=0 en=%b",
                 c, estado, en, EN_FETCH);
      end
      next_cycle();
    end
    mem_pronto = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      tests_run++;
      if (estado !== 3'd6 || erro !== 1'b1 || en !== EN_NONE) begin
        tests_failed++;
        $display("FAIL timeout_erro cyc=%0d estado=%0d erro=%b en=%b exp estado=6 erro=1 en=0",
                 c, estado, erro, en);
      end
      next_cycle();
    end
    // Access completes exactly on the last allowed cycle.
    do_reset();
    for (int c = 0; c < MAX_ESPERA; c++) next_cycle();
    mem_pronto = 1'b1;
    @(negedge clock);
    tests_run++;
    if (en !== EN_IR) begin
      tests_failed++;
      $display("FAIL timeout_edge_fetch en=%b exp=%b", en, EN_IR);
    end
    next_cycle();
    @(negedge clock);
    tests_run++;
    if (estado !== 3'd1 || erro !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_edge_decode estado=%0d erro=%b exp estado=1 erro=0", estado, erro);
    end
    // Data access stalls forever in MEMORIA.
    do_reset();
    set_dec(0, 0, 0, 0, 0, 1);
    mem_pronto = 1'b1;
    next_cycle();
    mem_pronto = 1'b0;
    next_cycle();
    next_cycle();
    for (int c = 0; c <= MAX_ESPERA; c++) next_cycle();
    @(negedge clock);
    tests_run++;
    if (estado !== 3'd6 || erro !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_memoria estado=%0d erro=%b exp estado=6 erro=1", estado, erro);
    end
    $display("[TB] test_timeout done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_halt();
    int bad;
    do_reset();
    set_dec(1, 0, 0, 0, 0, 0);
    mem_pronto = 1'b1;
    next_cycle();
    next_cycle();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      mem_pronto = 1'($urandom);
      Zero = 1'($urandom);
      @(negedge clock);
      tests_run++;
      if (estado !== 3'd5 || parado !== 1'b1 || en !== EN_NONE || erro !== 1'b0) begin
        tests_failed++;
        $display("FAIL halt_hold cyc=%0d estado=%0d parado=%b en=%b exp estado=5 parado=1 en=0",
                 c, estado, parado, en);
      end
      next_cycle();
    end
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (parado !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_reset_mask parado=%b exp=0", parado);
    end
    next_cycle();
    reset = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    tests_run++;
    if (estado !== 3'd0 || parado !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_reset estado=%0d parado=%b exp estado=0 parado=0", estado, parado);
    end
    $display("[TB] test_halt done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_illegal_mem();
    do_reset();
    set_dec(0, 1, 0, 0, 1, 1);
    mem_pronto = 1'b1;
    next_cycle();
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      tests_run++;
      if (estado !== 3'd6 || erro !== 1'b1 || en !== EN_NONE) begin
        tests_failed++;
        $display("FAIL illegal_mem cyc=%0d estado=%0d erro=%b en=%b exp estado=6 erro=1 en=0",
                 c, estado, erro, en);
      end
      next_cycle();
    end
    $display("[TB] test_illegal_mem done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_mem();
    do_reset();
    set_dec(0, 0, 0, 0, 0, 1);
    mem_pronto = 1'b1;
    next_cycle();
    mem_pronto = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clock);
    tests_run++;
    if (estado !== 3'd3 || EscMemDados !== 1'b1) begin
      tests_failed++;
      $display("FAIL midmem_pre estado=%0d wr=%b exp estado=3 wr=1", estado, EscMemDados);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (en !== EN_NONE) begin
      tests_failed++;
      $display("FAIL midmem_drop en=%b exp=0", en);
    end
    next_cycle();
    @(negedge clock);
    tests_run++;
    if (estado !== 3'd0) begin
      tests_failed++;
      $display("FAIL midmem_estado estado=%0d exp=0", estado);
    end
    reset = 1'b1;
    $display("[TB] test_reset_mid_mem done");
  endtask

  // ---------------------------------------------------------------------------
  // Random back-to-back instruction stream. Each instruction is expanded into
  // its phase list (fetch with wf wait cycles, decode, execute, optional
  // memory phase with wm wait cycles, optional writeback).
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0] st;
    logic [6:0] en;
    logic       pr;
  } cyc_t;

  task automatic test_random();
    cyc_t       q[$];
    cyc_t       e;
    int         kind, wf, wm, total, cyc;
    logic       r, b, s, lm, em, z, desv;
    total = 0;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 5));
      wf = int'($urandom_range(0, 4));
      wm = int'($urandom_range(0, 4));
      z  = 1'($urandom);
      r = 0; b = 0; s = 0; lm = 0; em = 0;
      case (kind)
        0: r = 1;                        // ALU op
        1: begin lm = 1; r = 1; end      // load
        2: em = 1;                       // store
        3: begin b = 1; r = 1'($urandom); end  // beq (writeback suppressed)
        4: begin s = 1; r = 1'($urandom); end  // jump
        default: ;                       // nop
      endcase
      desv = s | (b & z);
      q.delete();
      for (int i = 0; i < wf; i++) q.push_back('{3'd0, EN_FETCH, 1'b0});
      q.push_back('{3'd0, EN_IR, 1'b1});
      q.push_back('{3'd1, EN_NONE, 1'b0});
      q.push_back('{3'd2, desv ? EN_DESV : EN_NONE, 1'b0});
      if (lm || em) begin
        for (int i = 0; i <= wm; i++)
          q.push_back('{3'd3, (lm ? EN_RD : EN_NONE) | (em ? EN_WR : EN_NONE), i == wm});
        if (lm) q.push_back('{3'd4, EN_REG, 1'b0});
      end else if (r && !b && !s) begin
        q.push_back('{3'd4, EN_REG, 1'b0});
      end
      set_dec(0, r, b, s, lm, em);
      Zero = z;
      cyc = 0;
      while (q.size() > 0) begin
        e = q.pop_front();
        mem_pronto = e.pr;
        @(negedge clock);
        tests_run++;
        if (estado !== e.st || en !== e.en || erro !== 1'b0 || parado !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand instr=%0d kind=%0d cyc=%0d estado=%0d en=%b exp estado=%0d en=%b",
                   n, kind, cyc, estado, en, e.st, e.en);
        end
        next_cycle();
        cyc++;
        total++;
      end
      $display("[TB] rand instr=%0d kind=%0d wf=%0d wm=%0d cycles=%0d", n, kind, wf, wm, cyc);
    end
`ifdef CONTADOR_CICLOS_EN
    @(negedge clock);
    tests_run++;
    if (ciclos !== 32'(total) || instrucoes !== 32'd40) begin
      tests_failed++;
      $display("FAIL counters ciclos=%0d instrucoes=%0d exp ciclos=%0d instrucoes=40",
               ciclos, instrucoes, total);
    end
`endif
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_timeout();
    test_halt();
    test_illegal_mem();
    test_reset_mid_mem();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
